// File: rtl/aes_cipher_iter.sv
// aes_cipher_iter: iterative AES encryption core, one round per clock.
//
// A single 128-bit state register is folded through SubBytes, ShiftRows,
// MixColumns and AddRoundKey once per cycle. The round count is set by
// NUM_ROUNDS (10/12/14), so one datapath serves AES-128/192/256. Round
// keys come from an external store: the core drives key_idx and expects
// the matching round_key back combinationally in the same cycle.
//
// Byte order: byte 0 of any 128-bit block sits at bits [0:7]. The AES state
// is column-major, so byte i is row (i % 4), column (i / 4).
//
// Optional feature: define AES_OUT_BUF_EN to add an output holding register.
// The holding register lets ciphertext consumption overlap the next
// acceptance, which saves one cycle per block.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. A producer holds valid and its data stable until that edge.
// in_ready depends only on registered state, never on in_valid. Data
// offered while in_ready=0 is neither sampled nor stored.
module aes_cipher_iter #(
   parameter int NUM_ROUNDS = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [0:127] in_data,
   output logic [3:0]   key_idx,
   input  logic [0:127] round_key,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [0:127] out_data,
   output logic [1:0]   dbg_fsm
);

   // Only the three AES key sizes have defined round counts.
   if (NUM_ROUNDS != 10 && NUM_ROUNDS != 12 && NUM_ROUNDS != 14) begin : g_bad_rounds
      $error("aes_cipher_iter: NUM_ROUNDS must be 10, 12 or 14");
   end

   localparam logic [3:0] LAST = 4'(NUM_ROUNDS);

   // Forward S-box, 256 bytes packed so entry x is at bits [8x +: 8].
   localparam logic [0:2047] SBOX_TAB = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } fsm_t;

   // ---------------------------------------------------------------------
   // Round primitives
   // ---------------------------------------------------------------------
   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX_TAB[{b, 3'b000} +: 8];
   endfunction

   // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [0:127] sub_bytes(input logic [0:127] s);
      logic [0:127] r;
      r = '0;
      for (int i = 0; i < 16; i++) begin
         r[i*8 +: 8] = sbox(s[i*8 +: 8]);
      end
      return r;
   endfunction

   // Row r rotates left by r columns: out(row r, col c) = in(row r, col c+r).
   function automatic logic [0:127] shift_rows(input logic [0:127] s);
      logic [0:127] r;
      r = '0;
      for (int c = 0; c < 4; c++) begin
         for (int w = 0; w < 4; w++) begin
            r[(c*4 + w)*8 +: 8] = s[(((c + w) % 4)*4 + w)*8 +: 8];
         end
      end
      return r;
   endfunction

   function automatic logic [0:127] mix_columns(input logic [0:127] s);
      logic [0:127] r;
      logic [7:0]   a0, a1, a2, a3;
      r = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[c*32      +: 8];
         a1 = s[c*32 + 8  +: 8];
         a2 = s[c*32 + 16 +: 8];
         a3 = s[c*32 + 24 +: 8];
         r[c*32      +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
         r[c*32 + 8  +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
         r[c*32 + 16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
         r[c*32 + 24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
      return r;
   endfunction

   function automatic logic [0:127] add_round_key(input logic [0:127] s,
                                                  input logic [0:127] k);
      return s ^ k;
   endfunction

   // ---------------------------------------------------------------------
   // Registers and round datapath
   // ---------------------------------------------------------------------
   fsm_t         fsm_q, fsm_d;
   logic [3:0]   rnd_q;
   logic [0:127] state_q;
   logic [0:127] sb, sr, mc, round_res;
   logic         last_round;
   logic         accept;
   logic         fin_direct;  // final round may skip DONE
   logic         done_exit;   // DONE may return to IDLE this cycle

   assign last_round = (rnd_q == LAST);
   assign accept     = (fsm_q == S_IDLE) && in_valid;

   assign sb        = sub_bytes(state_q);
   assign sr        = shift_rows(sb);
   assign mc        = mix_columns(sr);
   // The final round drops MixColumns.
   assign round_res = add_round_key(last_round ? sr : mc, round_key);

   assign dbg_fsm = fsm_q;

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_q <= S_IDLE;
      end else begin
         fsm_q <= fsm_d;
      end
   end

   // Next-state decode, in_ready and the round-key index.
   always_comb begin
      fsm_d    = fsm_q;
      in_ready = 1'b0;
      key_idx  = 4'd0;
      case (fsm_q)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) fsm_d = S_RUN;
         end
         S_RUN: begin
            key_idx = rnd_q;
            if (last_round) fsm_d = fin_direct ? S_IDLE : S_DONE;
         end
         S_DONE: begin
            if (done_exit) fsm_d = S_IDLE;
         end
         default: fsm_d = S_IDLE;
      endcase
   end

   // State register and round counter: load with the whitening key on
   // acceptance, then apply one round per cycle while running.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= '0;
         rnd_q   <= 4'd0;
      end else if (accept) begin
         state_q <= add_round_key(in_data, round_key);
         rnd_q   <= 4'd1;
      end else if (fsm_q == S_RUN) begin
         state_q <= round_res;
         rnd_q   <= last_round ? 4'd0 : rnd_q + 4'd1;
      end
   end

`ifdef AES_OUT_BUF_EN
   // ---------------------------------------------------------------------
   // Output holding register. The final round (or a result parked in DONE)
   // moves into it whenever it is empty or being drained this cycle, which
   // frees the core to accept the next block while the consumer reads.
   // ---------------------------------------------------------------------
   logic         hold_v_q;
   logic [0:127] hold_q;
   logic         hold_free;
   logic         fin_to_hold;
   logic         done_to_hold;

   assign hold_free    = !hold_v_q || out_ready;
   assign fin_to_hold  = (fsm_q == S_RUN) && last_round && hold_free;
   assign done_to_hold = (fsm_q == S_DONE) && hold_free;
   assign fin_direct   = hold_free;
   assign done_exit    = hold_free;

   // Holding register fill/drain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_q   <= '0;
         hold_v_q <= 1'b0;
      end else if (fin_to_hold) begin
         hold_q   <= round_res;
         hold_v_q <= 1'b1;
      end else if (done_to_hold) begin
         hold_q   <= state_q;
         hold_v_q <= 1'b1;
      end else if (out_ready) begin
         hold_v_q <= 1'b0;
      end
   end

   assign out_valid = hold_v_q;
   assign out_data  = hold_q;
`else
   // Without a holding register the result is presented straight from the
   // state register while parked in DONE; intermediate rounds stay hidden.
   assign fin_direct = 1'b0;
   assign done_exit  = out_ready;
   assign out_valid  = (fsm_q == S_DONE);
   assign out_data   = out_valid ? state_q : '0;
`endif

endmodule
